// File: rtl/aib_link_bringup_ctrl.sv
// AIB link bring-up controller.
// Sequences adapter reset release, DCC/DLL lock requests and MAC-ready
// across the active channels, watches for transfer-enable and word
// alignment with an optional timeout, and reports link-up or an error cause.
module aib_link_bringup_ctrl #(
    parameter int NBR_CHNLS    = 24,
    parameter int ACTIVE_CHNLS = 24,
    parameter int RST_CYCLES   = 8
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 start,
    input  logic [15:0]          timeout_value,
    input  logic [NBR_CHNLS-1:0] ms_tx_transfer_en,
    input  logic [NBR_CHNLS-1:0] ms_rx_transfer_en,
    input  logic [NBR_CHNLS-1:0] m_rx_align_done,
    input  logic [NBR_CHNLS-1:0] fs_mac_rdy,
    output logic [NBR_CHNLS-1:0] ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0] ms_rx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0] ms_tx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0] ns_mac_rdy,
    output logic                 link_up,
    output logic                 link_err,
    output logic [1:0]           err_code,
    output logic [2:0]           state
);

    // Active channels occupy the low ACTIVE_CHNLS bits.
    localparam logic [NBR_CHNLS-1:0] MASK = {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);
    localparam int                   CW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0]        RST_LAST = CW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RST_HOLD   = 3'd1,
        S_WAIT_XFER  = 3'd2,
        S_WAIT_ALIGN = 3'd3,
        S_LINK_UP    = 3'd4,
        S_ERROR      = 3'd5
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_timer;
    logic [CW-1:0]          r_rst_cnt;
    logic [NBR_CHNLS-1:0]   r_adapter_rstn;
    logic [NBR_CHNLS-1:0]   r_lock_req;
    logic [NBR_CHNLS-1:0]   r_mac_rdy;
    logic                   r_link_up;
    logic                   r_link_err;
    logic [1:0]             r_err_code;

    state_t                 w_nxt;
    logic [1:0]             w_err_new;
    logic                   w_xfer_ok;
    logic                   w_align_ok;
    logic                   w_tmo;

    // Next-state selection; abort beats every other transition and the
    // exit condition beats a coincident timeout.
    always_comb begin
        w_nxt      = r_state;
        w_err_new  = 2'd0;
        w_xfer_ok  = ((ms_tx_transfer_en & ms_rx_transfer_en & MASK) == MASK);
        w_align_ok = ((m_rx_align_done & fs_mac_rdy & MASK) == MASK);
        w_tmo      = (timeout_value != 16'd0) && (r_timer == (timeout_value - 16'd1));
        case (r_state)
            S_IDLE: begin
                if (start) w_nxt = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                if (!start)                   w_nxt = S_IDLE;
                else if (r_rst_cnt == RST_LAST) w_nxt = S_WAIT_XFER;
            end
            S_WAIT_XFER: begin
                if (!start)         w_nxt = S_IDLE;
                else if (w_xfer_ok) w_nxt = S_WAIT_ALIGN;
                else if (w_tmo) begin
                    w_nxt     = S_ERROR;
                    w_err_new = 2'd1;
                end
            end
            S_WAIT_ALIGN: begin
                if (!start)          w_nxt = S_IDLE;
                else if (w_align_ok) w_nxt = S_LINK_UP;
                else if (w_tmo) begin
                    w_nxt     = S_ERROR;
                    w_err_new = 2'd2;
                end
            end
            S_LINK_UP: begin
                if (!start)          w_nxt = S_IDLE;
                else if (!w_xfer_ok) begin
                    w_nxt     = S_ERROR;
                    w_err_new = 2'd3;
                end
            end
            S_ERROR: begin
                if (!start) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // State, counters and outputs registered from the next state so that
    // outputs move on the same edge as the state.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_rst_cnt      <= '0;
            r_adapter_rstn <= '0;
            r_lock_req     <= '0;
            r_mac_rdy      <= '0;
            r_link_up      <= 1'b0;
            r_link_err     <= 1'b0;
            r_err_code     <= 2'd0;
        end else begin
            r_state <= w_nxt;

            if (w_nxt != r_state)
                r_timer <= '0;
            else if (((r_state == S_WAIT_XFER) || (r_state == S_WAIT_ALIGN)) && (r_timer != 16'hFFFF))
                r_timer <= r_timer + 16'd1;

            if (w_nxt != r_state)
                r_rst_cnt <= '0;
            else if (r_state == S_RST_HOLD)
                r_rst_cnt <= r_rst_cnt + 1'b1;

            r_adapter_rstn <= ((w_nxt == S_WAIT_XFER) || (w_nxt == S_WAIT_ALIGN) || (w_nxt == S_LINK_UP)) ? MASK : '0;
            r_lock_req     <= ((w_nxt == S_WAIT_XFER) || (w_nxt == S_WAIT_ALIGN) || (w_nxt == S_LINK_UP)) ? MASK : '0;
            r_mac_rdy      <= ((w_nxt == S_WAIT_ALIGN) || (w_nxt == S_LINK_UP)) ? MASK : '0;
            r_link_up      <= (w_nxt == S_LINK_UP);
            r_link_err     <= (w_nxt == S_ERROR);

            // Cause is latched on ERROR entry and held until leaving ERROR.
            if (w_nxt == S_ERROR)
                r_err_code <= (r_state == S_ERROR) ? r_err_code : w_err_new;
            else
                r_err_code <= 2'd0;
        end
    end

    assign ns_adapter_rstn        = r_adapter_rstn;
    assign ms_rx_dcc_dll_lock_req = r_lock_req;
    assign ms_tx_dcc_dll_lock_req = r_lock_req;
    assign ns_mac_rdy             = r_mac_rdy;
    assign link_up                = r_link_up;
    assign link_err               = r_link_err;
    assign err_code               = r_err_code;
    assign state                  = r_state;

endmodule

// File: tb/tb_aib_link_bringup_ctrl.sv
// Self-checking bench for aib_link_bringup_ctrl: a full-width instance and a
// 4-channel instance share stimulus and are compared every cycle against a
// reference model built from entry timestamps and elapsed-cycle arithmetic.
module tb_aib_link_bringup_ctrl;

    localparam int RC_A = 8;
    localparam int RC_B = 3;
    localparam logic [23:0] ONES = 24'hFF_FFFF;

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        start;
    logic [15:0] timeout_value;
    logic [23:0] tx_en, rx_en, align_done, fs_rdy;

    logic [23:0] rstn_a, rxlk_a, txlk_a, mrdy_a;
    logic        lu_a, le_a;
    logic [1:0]  ec_a;
    logic [2:0]  st_a;
    logic [23:0] rstn_b, rxlk_b, txlk_b, mrdy_b;
    logic        lu_b, le_b;
    logic [1:0]  ec_b;
    logic [2:0]  st_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase number (spec encoding), edge index of phase entry, latched cause.
    int          ph[2];
    int          ent[2];
    int          cause[2];
    int          edge_n = 0;
    logic [23:0] msk[2];
    int          rcyc[2];

    always #5 clk_wr = ~clk_wr;

    aib_link_bringup_ctrl #(.NBR_CHNLS(24), .ACTIVE_CHNLS(24), .RST_CYCLES(RC_A)) u_full (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .start(start), .timeout_value(timeout_value),
        .ms_tx_transfer_en(tx_en), .ms_rx_transfer_en(rx_en),
        .m_rx_align_done(align_done), .fs_mac_rdy(fs_rdy),
        .ns_adapter_rstn(rstn_a), .ms_rx_dcc_dll_lock_req(rxlk_a), .ms_tx_dcc_dll_lock_req(txlk_a),
        .ns_mac_rdy(mrdy_a), .link_up(lu_a), .link_err(le_a), .err_code(ec_a), .state(st_a)
    );

    aib_link_bringup_ctrl #(.NBR_CHNLS(24), .ACTIVE_CHNLS(4), .RST_CYCLES(RC_B)) u_part (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .start(start), .timeout_value(timeout_value),
        .ms_tx_transfer_en(tx_en), .ms_rx_transfer_en(rx_en),
        .m_rx_align_done(align_done), .fs_mac_rdy(fs_rdy),
        .ns_adapter_rstn(rstn_b), .ms_rx_dcc_dll_lock_req(rxlk_b), .ms_tx_dcc_dll_lock_req(txlk_b),
        .ns_mac_rdy(mrdy_b), .link_up(lu_b), .link_err(le_b), .err_code(ec_b), .state(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; ent[d] = edge_n; cause[d] = 0;
        end
    endtask

    // One rising edge of the reference: elapsed = cycles spent in phase before this edge.
    task automatic model_edge(input int d);
        int  el;
        int  np;
        bit  xok, aok, tmo;
        el  = edge_n - ent[d] - 1;
        if (el > 65535) el = 65535;
        xok = ((tx_en & rx_en & msk[d]) == msk[d]);
        aok = ((align_done & fs_rdy & msk[d]) == msk[d]);
        tmo = (timeout_value != 0) && (el == int'(timeout_value) - 1);
        np  = ph[d];
        if (ph[d] == 0) begin
            if (start) np = 1;
        end else if (!start) begin
            np = 0;
        end else if (ph[d] == 1) begin
            if (el == rcyc[d] - 1) np = 2;
        end else if (ph[d] == 2) begin
            if (xok) np = 3; else if (tmo) begin np = 5; cause[d] = 1; end
        end else if (ph[d] == 3) begin
            if (aok) np = 4; else if (tmo) begin np = 5; cause[d] = 2; end
        end else if (ph[d] == 4) begin
            if (!xok) begin np = 5; cause[d] = 3; end
        end
        if (np != ph[d]) begin
            ent[d] = edge_n;
            if (np == 0) cause[d] = 0;
        end
        ph[d] = np;
    endtask

    task automatic check_all();
        logic [23:0] rstn, rxl, txl, mrdy, e_on, e_mac;
        logic        lu, le;
        logic [1:0]  ec;
        logic [2:0]  st;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                rstn = rstn_a; rxl = rxlk_a; txl = txlk_a; mrdy = mrdy_a; lu = lu_a; le = le_a; ec = ec_a; st = st_a;
            end else begin
                rstn = rstn_b; rxl = rxlk_b; txl = txlk_b; mrdy = mrdy_b; lu = lu_b; le = le_b; ec = ec_b; st = st_b;
            end
            e_on  = (ph[d] >= 2 && ph[d] <= 4) ? msk[d] : 24'h0;
            e_mac = (ph[d] == 3 || ph[d] == 4) ? msk[d] : 24'h0;
            chk($sformatf("state[%0d]", d), 32'(st), 32'(ph[d]));
            chk($sformatf("adapter_rstn[%0d]", d), 32'(rstn), 32'(e_on));
            chk($sformatf("rx_lock_req[%0d]", d), 32'(rxl), 32'(e_on));
            chk($sformatf("tx_lock_req[%0d]", d), 32'(txl), 32'(e_on));
            chk($sformatf("mac_rdy[%0d]", d), 32'(mrdy), 32'(e_mac));
            chk($sformatf("link_up[%0d]", d), 32'(lu), 32'(ph[d] == 4));
            chk($sformatf("link_err[%0d]", d), 32'(le), 32'(ph[d] == 5));
            chk($sformatf("err_code[%0d]", d), 32'(ec), (ph[d] == 5) ? 32'(cause[d]) : 32'd0);
        end
    endtask

    // Inputs are changed only at edge+1, so they are stable across each edge.
    task automatic tick();
        @(posedge clk_wr);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset();
        #2 rst_wr_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk_wr);
        edge_n++;
        #1;
        model_reset();
        check_all();
        rst_wr_n = 1'b1;
    endtask

    task automatic wait_state_a(input logic [2:0] want, input int bound);
        int n = 0;
        while (st_a !== want && n < bound) begin
            tick();
            n++;
        end
        chk("wait_state_full", 32'(st_a), 32'(want));
    endtask

    function automatic logic [23:0] rvec();
        logic [23:0] v;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: v = ONES;
            7: begin v = ONES; v[$urandom_range(0, 23)] = 1'b0; end
            8: v = 24'($urandom);
            default: v = 24'h0;
        endcase
        return v;
    endfunction

    initial begin
        int hold_cnt;
        int tmo_cnt;
        msk[0] = ONES; msk[1] = 24'h00000F;
        rcyc[0] = RC_A; rcyc[1] = RC_B;
        rst_wr_n = 1'b1; start = 1'b0; timeout_value = 16'd100;
        tx_en = '0; rx_en = '0; align_done = '0; fs_rdy = '0;
        @(posedge clk_wr); #1;
        pulse_reset();

        // Nominal bring-up.
        start = 1'b1;
        hold_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (st_a == 3'd1 && rstn_a == 24'h0) hold_cnt++;
        end
        chk("rst_hold_len", 32'(hold_cnt), 32'd8);
        tx_en = ONES; rx_en = ONES;
        repeat (10) tick();
        align_done = ONES; fs_rdy = ONES;
        repeat (3) tick();
        chk("nominal_state", 32'(st_a), 32'd4);
        chk("nominal_link_up", 32'(lu_a), 32'd1);
        chk("nominal_no_err", 32'(le_a), 32'd0);

        // Single-cycle link drop on rx bit 0.
        rx_en[0] = 1'b0;
        tick();
        rx_en[0] = 1'b1;
        tick();
        chk("drop_err_code", 32'(ec_a), 32'd3);
        chk("drop_link_up", 32'(lu_a), 32'd0);
        start = 1'b0;
        tick();

        // Transfer-enable timeout: bit 3 never set.
        timeout_value = 16'd50;
        tx_en = ONES; tx_en[3] = 1'b0; rx_en = ONES; align_done = '0; fs_rdy = '0;
        start = 1'b1;
        wait_state_a(3'd2, 40);
        tmo_cnt = 0;
        while (st_a == 3'd2 && tmo_cnt < 200) begin
            tick();
            tmo_cnt++;
        end
        chk("xfer_timeout_cycles", 32'(tmo_cnt), 32'd50);
        chk("xfer_timeout_code", 32'(ec_a), 32'd1);
        chk("xfer_timeout_rstn", 32'(rstn_a), 32'd0);
        start = 1'b0;
        tick();
        chk("timeout_clear", 32'(le_a), 32'd0);

        // Partial mask: only [3:0] driven high, timeout disabled.
        timeout_value = 16'd0;
        tx_en = 24'hF; rx_en = 24'hF; align_done = 24'hF; fs_rdy = 24'hF;
        start = 1'b1;
        repeat (12) tick();
        chk("partial_state", 32'(st_b), 32'd4);
        chk("partial_upper_rstn", 32'(rstn_b[23:4]), 32'd0);
        start = 1'b0;
        tick();

        // Exit condition coincides with timeout in WAIT_XFER and in WAIT_ALIGN.
        timeout_value = 16'd20;
        tx_en = '0; rx_en = '0; align_done = '0; fs_rdy = '0;
        start = 1'b1;
        wait_state_a(3'd2, 40);
        repeat (19) tick();
        tx_en = ONES; rx_en = ONES;
        tick();
        chk("xfer_tie_state", 32'(st_a), 32'd3);
        repeat (19) tick();
        align_done = ONES; fs_rdy = ONES;
        tick();
        chk("align_tie_state", 32'(st_a), 32'd4);
        start = 1'b0;
        tick();

        // Abort from WAIT_ALIGN.
        align_done = '0;
        start = 1'b1;
        wait_state_a(3'd3, 40);
        start = 1'b0;
        tick();
        chk("abort_align", 32'(st_a), 32'd0);

        // Reset pulse in LINK_UP.
        timeout_value = 16'd0;
        align_done = ONES; start = 1'b1;
        wait_state_a(3'd4, 40);
        pulse_reset();
        chk("reset_link_up", 32'(lu_a), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (start) begin
                if ($urandom_range(0, 59) == 0) start = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: timeout_value = 16'd0;
                    1: timeout_value = 16'hFFFF;
                    default: timeout_value = 16'($urandom_range(1, 40));
                endcase
            end
            if ($urandom_range(0, 7) == 0) tx_en = rvec();
            if ($urandom_range(0, 7) == 0) rx_en = rvec();
            if ($urandom_range(0, 7) == 0) align_done = rvec();
            if ($urandom_range(0, 7) == 0) fs_rdy = rvec();
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aib_link_bringup_ctrl.md
AIB_LINK_BRINGUP_CTRL -- requirements
Module: aib_link_bringup_ctrl

Interface
REQ-001 Parameter NBR_CHNLS, default 24: total AIB channels; width of all per-channel vectors.
REQ-002 Parameter ACTIVE_CHNLS, default 24: channels in use; active mask = low ACTIVE_CHNLS bits set, upper bits 0; range 1..NBR_CHNLS.
REQ-003 Parameter RST_CYCLES, default 8: cycles ns_adapter_rstn is held low in RST_HOLD; must be >= 1.
REQ-004 Port clk_wr, input, 1: single clock for all logic.
REQ-005 Port rst_wr_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: level request to bring the link up; deassertion aborts.
REQ-007 Port timeout_value, input, 16: wait-state timeout in cycles; 0 disables timeout.
REQ-008 Port ms_tx_transfer_en, input, NBR_CHNLS: PHY TX transfer-enable per channel.
REQ-009 Port ms_rx_transfer_en, input, NBR_CHNLS: PHY RX transfer-enable per channel.
REQ-010 Port m_rx_align_done, input, NBR_CHNLS: RX word alignment done per channel.
REQ-011 Port fs_mac_rdy, input, NBR_CHNLS: far-side MAC ready per channel.
REQ-012 Port ns_adapter_rstn, output, NBR_CHNLS: adapter reset release per channel.
REQ-013 Port ms_rx_dcc_dll_lock_req / ms_tx_dcc_dll_lock_req, output, NBR_CHNLS each: DCC/DLL lock requests.
REQ-014 Port ns_mac_rdy, output, NBR_CHNLS: near-side MAC ready.
REQ-015 Port link_up, output, 1: link operational; used as AXI tx_online/rx_online.
REQ-016 Port link_err, output, 1; err_code, output, 2: error flag and cause (1 = transfer-enable timeout, 2 = align timeout, 3 = link drop).
REQ-017 Port state, output, 3: current FSM state encoding.

Function
REQ-018 States and encodings: IDLE=0, RST_HOLD=1, WAIT_XFER=2, WAIT_ALIGN=3, LINK_UP=4, ERROR=5.
REQ-019 All outputs are registered and reflect the current state: outputs change in the same cycle `state` changes.
REQ-020 IDLE: all outputs 0; start=1 -> RST_HOLD.
REQ-021 RST_HOLD: ns_adapter_rstn=0; count exactly RST_CYCLES cycles, then -> WAIT_XFER.
REQ-022 WAIT_XFER: ns_adapter_rstn=mask and both lock_req=mask. When (ms_tx_transfer_en & ms_rx_transfer_en & mask)==mask -> WAIT_ALIGN.
REQ-023 WAIT_ALIGN: WAIT_XFER outputs, plus ns_mac_rdy=mask. When (m_rx_align_done & fs_mac_rdy & mask)==mask -> LINK_UP.
REQ-024 LINK_UP: WAIT_ALIGN outputs, plus link_up=1.
- Any active bit of ms_tx_transfer_en or ms_rx_transfer_en at 0 -> ERROR with err_code=3.
- Align/mac_rdy drops are ignored in LINK_UP.
REQ-025 Timer (16-bit):
- Cleared on every state entry.
- Increments each cycle in WAIT_XFER and WAIT_ALIGN.
- Saturates at 0xFFFF.
REQ-026 Timeout fires when timeout_value!=0 and timer==timeout_value-1 with the exit condition false.
- Next state ERROR.
- err_code=1 from WAIT_XFER, 2 from WAIT_ALIGN.
REQ-027 If the exit condition and timeout are true in the same cycle, the exit condition wins.
REQ-028 ERROR: link_err=1 and err_code held; all other outputs 0 (adapters held in reset). start=0 -> IDLE, which clears link_err and err_code.
REQ-029 start=0 in RST_HOLD, WAIT_XFER, WAIT_ALIGN or LINK_UP -> IDLE next cycle; abort has priority over all other transitions.
REQ-030 Bits of input vectors outside the mask are ignored; outputs outside the mask are always 0.

Reset
REQ-031 rst_wr_n=0 asynchronously forces state=IDLE, all outputs 0, timer and RST_HOLD counter 0, err_code=0. This applies in any state, including LINK_UP.
REQ-032 After rst_wr_n deasserts, first transition is IDLE -> RST_HOLD on the first rising clk_wr edge with start=1.

Verification
REQ-033 Nominal bring-up, ACTIVE_CHNLS=24, RST_CYCLES=8, timeout=100:
- Stimulus: start=1; transfer_en all ones 20 cycles later; align_done and fs_mac_rdy 10 cycles after that.
- Required: ns_adapter_rstn low 8 cycles; link_up=1; state=4; no error.
REQ-034 Transfer-enable timeout, timeout_value=50:
- Stimulus: transfer_en bit 3 never set.
- Required: ERROR exactly 50 cycles after WAIT_XFER entry; link_err=1; err_code=1; ns_adapter_rstn=0.
- Then start=0 -> IDLE, link_err=0.
REQ-035 Partial mask, ACTIVE_CHNLS=4:
- Stimulus: only inputs [3:0] driven high, upper bits 0.
- Required: LINK_UP reached; outputs [23:4] stay 0.
REQ-036 Link drop: in LINK_UP, ms_rx_transfer_en[0]=0 for 1 cycle -> ERROR, err_code=3, link_up=0.
REQ-037 Boundary and abort cases:
- Exit condition and timeout in the same cycle -> WAIT_ALIGN (no error).
- start=0 in WAIT_ALIGN -> IDLE next cycle.
- rst_wr_n pulsed low mid-LINK_UP -> all outputs 0 immediately, without waiting for a clock edge.
